// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute controller for the register-file/ALU datapath.
// Each instruction goes through FETCH (req/valid handshake), EXEC (one settle cycle)
// and WB (one-cycle write enable). The sequencer stops on a HALT_INSTR fetch or on a
// stop request, which is honoured only after the instruction in flight retires.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, start_pc begin fetching at start_pc (accepted in IDLE or HALT only)
//   stop            stop after the current instruction retires
//   imem_req/addr   fetch request and word address (held until imem_valid)
//   imem_rdata/valid fetched word and its qualifier
//   instr           instruction register driving the datapath
//   we              datapath write enable, one-cycle pulse in WB
//   pc              program counter
//   busy, halted    status: in FETCH/EXEC/WB, in HALT
//   retired         saturating count of instructions that completed WB
module instr_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stop,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [31:0]       instr,
    output logic              we,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t state;
    logic   stop_latch;

    // Output flags {imem_req, busy, halted, we} for the state being entered, so they
    // are registered alongside the state itself.
    function automatic logic [3:0] flags_for(input state_t s);
        logic [3:0] f;
        f = 4'b0000;
        case (s)
            S_FETCH: f = 4'b1100;
            S_EXEC:  f = 4'b0100;
            S_WB:    f = 4'b0101;
            S_HALT:  f = 4'b0010;
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

    // The fetch address is the program counter itself.
    assign imem_addr = pc;

    // Sequencer state, datapath control and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                          <= S_IDLE;
            pc                             <= '0;
            instr                          <= '0;
            retired                        <= '0;
            stop_latch                     <= 1'b0;
            {imem_req, busy, halted, we}   <= 4'b0000;
        end else begin
            case (state)
                // HALT restarts exactly like IDLE; a simultaneous stop arms the latch
                // so that exactly one instruction runs.
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc                           <= start_pc;
                        stop_latch                   <= stop;
                        state                        <= S_FETCH;
                        {imem_req, busy, halted, we} <= flags_for(S_FETCH);
                    end
                end

                S_FETCH: begin
                    if (stop) begin
                        stop_latch <= 1'b1;
                    end
                    if (imem_valid) begin
                        // A halt word is not loaded into instr and is not retired.
                        if (imem_rdata == HALT_INSTR) begin
                            state                        <= S_HALT;
                            {imem_req, busy, halted, we} <= flags_for(S_HALT);
                        end else begin
                            instr                        <= imem_rdata;
                            state                        <= S_EXEC;
                            {imem_req, busy, halted, we} <= flags_for(S_EXEC);
                        end
                    end
                end

                S_EXEC: begin
                    if (stop) begin
                        stop_latch <= 1'b1;
                    end
                    state                        <= S_WB;
                    {imem_req, busy, halted, we} <= flags_for(S_WB);
                end

                S_WB: begin
                    pc <= pc + ADDR_W'(1);
                    if (retired != {CNT_W{1'b1}}) begin
                        retired <= retired + CNT_W'(1);
                    end
                    if (stop_latch || stop) begin
                        stop_latch                   <= 1'b0;
                        state                        <= S_IDLE;
                        {imem_req, busy, halted, we} <= flags_for(S_IDLE);
                    end else begin
                        state                        <= S_FETCH;
                        {imem_req, busy, halted, we} <= flags_for(S_FETCH);
                    end
                end

                default: begin
                    stop_latch                   <= 1'b0;
                    state                        <= S_IDLE;
                    {imem_req, busy, halted, we} <= flags_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction memory with programmable wait states,
// a small register-file model written on we, directed program runs from a table,
// and hand-written sequences for reset, stop and counter saturation.
module tb_instr_sequencer;

    localparam logic [31:0] HALT_W = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_init;

    // Main instance (default parameters).
    logic        start;
    logic [7:0]  start_pc;
    logic        stop;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        we;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    // Narrow-counter instance on an always-ready memory returning an add.
    logic        s_start;
    logic [7:0]  s_start_pc;
    logic        s_stop;
    logic        s_req;
    logic [7:0]  s_addr;
    logic [31:0] s_rdata;
    logic        s_valid;
    logic [31:0] s_instr;
    logic        s_we;
    logic [7:0]  s_pc;
    logic        s_busy;
    logic        s_halted;
    logic [3:0]  s_retired;

    logic [31:0] mem [256];
    logic [31:0] rf [32];
    int          wait_cycles;
    int          wait_cnt;
    int          we_edges;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    instr_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .instr(instr), .we(we), .pc(pc), .busy(busy),
        .halted(halted), .retired(retired)
    );

    instr_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .start_pc(s_start_pc), .stop(s_stop),
        .imem_req(s_req), .imem_addr(s_addr), .imem_rdata(s_rdata),
        .imem_valid(s_valid), .instr(s_instr), .we(s_we), .pc(s_pc), .busy(s_busy),
        .halted(s_halted), .retired(s_retired)
    );

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    assign s_valid = s_req;
    assign s_rdata = rtype(7'h00, 5'd2, 5'd1, 5'd8);

    // Memory responder: answers a held request after wait_cycles idle cycles.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt == wait_cycles) begin
                imem_valid <= 1'b1;
                imem_rdata <= mem[imem_addr];
                wait_cnt   <= 0;
            end else begin
                imem_valid <= 1'b0;
                wait_cnt   <= wait_cnt + 1;
            end
        end else begin
            imem_valid <= 1'b0;
            wait_cnt   <= 0;
        end
    end

    // Register-file model: commits add/sub on the edge that ends a we cycle.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1]    <= 32'd100;
            rf[2]    <= 32'd30;
            we_edges <= 0;
        end else if (we) begin
            we_edges <= we_edges + 1;
            if (instr[6:0] == 7'h33 && instr[14:12] == 3'b000) begin
                if (instr[31:25] == 7'h20)
                    rf[instr[11:7]] <= rf[instr[19:15]] - rf[instr[24:20]];
                else
                    rf[instr[11:7]] <= rf[instr[19:15]] + rf[instr[24:20]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start at p and watch until HALT or back to IDLE. Cycle k is the k-th cycle after
    // the start edge; stop is driven high for the cycle numbered stop_k.
    task automatic run_prog(input logic [7:0] p, input int wc, input int stop_k,
                            input logic stop0, output int we_n, output int w0,
                            output int w1, output int req_n, output int k_end);
        logic       prev_req;
        logic [7:0] prev_addr;
        we_n = 0; w0 = 0; w1 = 0; req_n = 0; k_end = 0;
        prev_req = 1'b0; prev_addr = 8'd0;
        wait_cycles = wc;
        @(negedge clk);
        start_pc = p;
        start    = 1'b1;
        stop     = stop0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (k == stop_k);
            if (we) begin
                if (we_n == 0) w0 = k;
                else if (we_n == 1) w1 = k;
                we_n++;
            end
            if (imem_req) begin
                req_n++;
                if (prev_req) check("addr_hold", 32'(imem_addr), 32'(prev_addr));
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
            if (halted || !busy) begin
                k_end = k;
                break;
            end
        end
        stop = 1'b0;
    endtask

    typedef struct {
        logic [7:0] pc0;
        int         wc;
        int         we_n;
        int         w0;
        int         w1;
        int         req_n;
        int         k_end;
        logic [7:0] pc_end;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          we_n, w0, w1, req_n, k_end;
        int          exp_ret;
        int          snap;
        int          cnt;
        logic        found;

        tbl[0] = '{8'd4,   0, 2, 3, 6,  3, 8,  8'd6};
        tbl[1] = '{8'd10,  2, 2, 5, 10, 9, 14, 8'd12};
        tbl[2] = '{8'd20,  0, 0, 0, 0,  1, 2,  8'd20};
        tbl[3] = '{8'd20,  3, 0, 0, 0,  4, 5,  8'd20};
        tbl[4] = '{8'hFF,  0, 1, 3, 0,  2, 5,  8'd0};
        tbl[5] = '{8'd4,   1, 2, 4, 8,  6, 11, 8'd6};

        for (int i = 0; i < 256; i++) mem[i] = rtype(7'h00, 5'd2, 5'd1, 5'd9);
        mem[4]     = rtype(7'h00, 5'd2, 5'd1, 5'd3);
        mem[5]     = rtype(7'h20, 5'd2, 5'd1, 5'd4);
        mem[6]     = HALT_W;
        mem[10]    = rtype(7'h00, 5'd2, 5'd1, 5'd5);
        mem[11]    = rtype(7'h20, 5'd2, 5'd1, 5'd6);
        mem[12]    = HALT_W;
        mem[20]    = HALT_W;
        mem[8'hFF] = rtype(7'h00, 5'd2, 5'd1, 5'd7);
        mem[0]     = HALT_W;

        rst = 1'b1; rf_init = 1'b1; wait_cycles = 0;
        start = 1'b0; start_pc = 8'd0; stop = 1'b0;
        s_start = 1'b0; s_start_pc = 8'd0; s_stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rf_init = 1'b0;
        @(negedge clk);

        check("rst_pc",      32'(pc),        32'd0);
        check("rst_instr",   instr,          32'd0);
        check("rst_retired", 32'(retired),   32'd0);
        check("rst_req",     32'(imem_req),  32'd0);
        check("rst_addr",    32'(imem_addr), 32'd0);
        check("rst_we",      32'(we),        32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_halted",  32'(halted),    32'd0);

        // Asynchronous reset in the middle of the first WB cycle.
        wait_cycles = 0;
        @(negedge clk);
        start_pc = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (we) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wb_reached", 32'(found), 32'd1);
        snap = we_edges;
        rst = 1'b1;
        #1;
        check("mid_rst_we",      32'(we),       32'd0);
        check("mid_rst_busy",    32'(busy),     32'd0);
        check("mid_rst_req",     32'(imem_req), 32'd0);
        check("mid_rst_pc",      32'(pc),       32'd0);
        check("mid_rst_instr",   instr,         32'd0);
        check("mid_rst_retired", 32'(retired),  32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_no_edge_we", 32'(we_edges), 32'(snap));
        check("mid_rst_rf3",        rf[3],          32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of complete program runs, each ending in HALT.
        exp_ret = 0;
        for (int i = 0; i < 6; i++) begin
            run_prog(tbl[i].pc0, tbl[i].wc, 0, 1'b0, we_n, w0, w1, req_n, k_end);
            exp_ret += tbl[i].we_n;
            check($sformatf("v%0d_we_count", i), 32'(we_n),  32'(tbl[i].we_n));
            if (tbl[i].we_n >= 1) check($sformatf("v%0d_we0_cycle", i), 32'(w0), 32'(tbl[i].w0));
            if (tbl[i].we_n >= 2) check($sformatf("v%0d_we1_cycle", i), 32'(w1), 32'(tbl[i].w1));
            check($sformatf("v%0d_req_cycles", i), 32'(req_n),  32'(tbl[i].req_n));
            check($sformatf("v%0d_halt_cycle", i), 32'(k_end),  32'(tbl[i].k_end));
            check($sformatf("v%0d_pc", i),         32'(pc),     32'(tbl[i].pc_end));
            check($sformatf("v%0d_addr", i),       32'(imem_addr), 32'(tbl[i].pc_end));
            check($sformatf("v%0d_halted", i),     32'(halted), 32'd1);
            check($sformatf("v%0d_busy", i),       32'(busy),   32'd0);
            check($sformatf("v%0d_retired", i),    32'(retired), 32'(exp_ret));
        end
        check("rf_x3_add", rf[3], 32'd130);
        check("rf_x4_sub", rf[4], 32'd70);
        check("rf_x5_add", rf[5], 32'd130);
        check("rf_x6_sub", rf[6], 32'd70);
        check("rf_x7_add", rf[7], 32'd130);

        // Stop during EXEC of the second instruction: it retires, then IDLE.
        run_prog(8'd30, 0, 5, 1'b0, we_n, w0, w1, req_n, k_end);
        exp_ret += 2;
        check("stop_we_count", 32'(we_n),    32'd2);
        check("stop_end",      32'(k_end),   32'd7);
        check("stop_busy",     32'(busy),    32'd0);
        check("stop_halted",   32'(halted),  32'd0);
        check("stop_pc",       32'(pc),      32'd32);
        check("stop_retired",  32'(retired), 32'(exp_ret));

        // Start and stop together in IDLE: exactly one instruction.
        run_prog(8'd30, 0, 0, 1'b1, we_n, w0, w1, req_n, k_end);
        exp_ret += 1;
        check("ss_we_count", 32'(we_n),    32'd1);
        check("ss_end",      32'(k_end),   32'd4);
        check("ss_pc",       32'(pc),      32'd31);
        check("ss_busy",     32'(busy),    32'd0);
        check("ss_retired",  32'(retired), 32'(exp_ret));

        // Narrow counter saturation; a start while busy must not move pc.
        @(negedge clk);
        s_start_pc = 8'h10; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k == 5) begin
                s_start = 1'b1;
                s_start_pc = 8'h80;
            end else begin
                s_start = 1'b0;
            end
            if (s_we) begin
                cnt++;
                if (cnt == 16) begin
                    check("sat_after_15", 32'(s_retired), 32'hF);
                    s_stop = 1'b1;
                    found = 1'b1;
                end
            end
            if (found) break;
            @(negedge clk);
        end
        check("sat_16_reached", 32'(found), 32'd1);
        @(negedge clk);
        s_stop = 1'b0; s_start = 1'b0;
        @(negedge clk);
        check("sat_retired", 32'(s_retired), 32'hF);
        check("sat_busy",    32'(s_busy),    32'd0);
        check("sat_pc",      32'(s_pc),      32'h20);
        check("sat_halted",  32'(s_halted),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
